// File: rtl/frame_pkg.sv
// Shared types and constants for the frame unpacker datapath.
package frame_pkg;

  localparam int FRAME_W = 130;
  localparam int PAY_W   = 128;
  localparam int HALF_W  = 64;

  // Mode tags produced by the packer; every other tag means an all-zero frame.
  localparam logic [1:0] MODE_DUP  = 2'b11;
  localparam logic [1:0] MODE_FULL = 2'b01;

  typedef enum logic [1:0] {
    KIND_NULL = 2'd0,
    KIND_FULL = 2'd1,
    KIND_DUP  = 2'd2
  } kind_e;

  // One decoded frame as stored in the output FIFO (133 bits).
  typedef struct packed {
    logic [PAY_W-1:0] data;
    logic             f;
    logic             g;
    kind_e            kind;
    logic             err;
  } entry_t;

endpackage

// File: rtl/frame_fifo.sv
// Synchronous FIFO of decoded entries with explicit occupancy tracking.
module frame_fifo
  import frame_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  logic   pop,
  input  entry_t wr_entry,
  output entry_t rd_entry,
  output logic   full,
  output logic   empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] occ;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (occ == OCC_W'(DEPTH));
  assign empty   = (occ == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Pointer and occupancy bookkeeping; push and pop together leave occupancy unchanged.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // Entry storage write.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; the empty flag masks stale contents at the output.
    if (do_push) mem[wr_ptr] <= wr_entry;
  end

  // Head entry reads as all-zero whenever nothing is buffered.
  always_comb begin
    rd_entry = empty ? '0 : mem[rd_ptr];
  end

endmodule

// File: rtl/frame_unpack.sv
// Receive-side frame decoder: mode decode, integrity check, output FIFO and statistics.
module frame_unpack
  import frame_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [FRAME_W-1:0] in_frame,
  input  logic [1:0]         in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PAY_W-1:0]   out_data,
  output logic               out_f,
  output logic               out_g,
  output logic [1:0]         out_kind,
  output logic               out_err,
  output logic [CNT_W-1:0]   frame_cnt,
  output logic [CNT_W-1:0]   err_cnt
);

  entry_t dec;
  entry_t head;
  logic   fifo_full;
  logic   fifo_empty;
  logic   accept;
  logic   take;

  assign in_ready  = ~fifo_full;
  assign out_valid = ~fifo_empty;
  assign accept    = in_valid & in_ready;
  assign take      = out_valid & out_ready;

  // Decode the presented frame according to its mode tag.
  always_comb begin
    // NOTE: defaulting the whole struct first keeps every path assigned, so no latch is inferred.
    dec = '0;
    case (in_mode)
      MODE_DUP: begin
        dec.kind = KIND_DUP;
        dec.f    = in_frame[FRAME_W-1];
        dec.data = {{HALF_W{1'b0}}, in_frame[HALF_W-1:0]};
        dec.err  = in_frame[PAY_W] | (in_frame[PAY_W-1:HALF_W] != in_frame[HALF_W-1:0]);
      end
      MODE_FULL: begin
        dec.kind = KIND_FULL;
        dec.f    = in_frame[FRAME_W-1];
        dec.g    = in_frame[PAY_W];
        dec.data = in_frame[PAY_W-1:0];
      end
      default: begin
        // The packer sends all zeros for null tags, so any set bit is corruption.
        dec.err = |in_frame;
      end
    endcase
  end

  frame_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (accept),
    .pop      (take),
    .wr_entry (dec),
    .rd_entry (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Head fields come straight from FIFO storage.
  always_comb begin
    out_data = head.data;
    out_f    = head.f;
    out_g    = head.g;
    out_kind = head.kind;
    out_err  = head.err;
  end

  // Saturating statistics counters for accepted frames and errored frames.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else if (accept) begin
      if (frame_cnt != '1)           frame_cnt <= frame_cnt + 1'b1;
      if (dec.err && err_cnt != '1)  err_cnt   <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_frame_unpack.sv
// Directed scoreboard bench for frame_unpack (DEPTH=2, CNT_W=4).
module tb_frame_unpack;
  import frame_pkg::*;

  localparam int DEPTH   = 2;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [FRAME_W-1:0] in_frame;
  logic [1:0]         in_mode;
  logic               out_valid;
  logic               out_ready;
  logic [PAY_W-1:0]   out_data;
  logic               out_f;
  logic               out_g;
  logic [1:0]         out_kind;
  logic               out_err;
  logic [CNT_W-1:0]   frame_cnt;
  logic [CNT_W-1:0]   err_cnt;

  entry_t exp_q[$];
  int     exp_frames;
  int     exp_errs;
  int     checks = 0;
  int     errors = 0;

  localparam logic [63:0] H_A = 64'hfedcba9876543210;
  localparam logic [63:0] H_B = 64'h0123456789abcdef;

  frame_unpack #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_frame  (in_frame),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_f     (out_f),
    .out_g     (out_g),
    .out_kind  (out_kind),
    .out_err   (out_err),
    .frame_cnt (frame_cnt),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [132:0] obs, input logic [132:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference decode written directly from the frame format.
  function automatic entry_t model(input logic [129:0] fr, input logic [1:0] md);
    entry_t e;
    e = '0;
    if (md == 2'b11) begin
      e.kind = KIND_DUP;
      e.f    = fr[129];
      e.data = {64'h0, fr[63:0]};
      e.err  = fr[128] || (fr[127:64] != fr[63:0]);
    end else if (md == 2'b01) begin
      e.kind = KIND_FULL;
      e.f    = fr[129];
      e.g    = fr[128];
      e.data = fr[127:0];
    end else begin
      e.err = (fr != '0);
    end
    return e;
  endfunction

  task automatic drive(input logic r, input logic v, input logic [1:0] md,
                       input logic [129:0] fr, input logic ordy);
    rst       = r;
    in_valid  = v;
    in_mode   = md;
    in_frame  = fr;
    out_ready = ordy;
  endtask

  // One clock: compare DUT against the scoreboard, update the model, advance.
  task automatic step();
    entry_t exp_head;
    entry_t nxt;
    int     occ;
    #1;
    if (rst) begin
      exp_q.delete();
      exp_frames = 0;
      exp_errs   = 0;
    end else begin
      occ = exp_q.size();
      check("in_ready", in_ready, occ < DEPTH);
      check("out_valid", out_valid, occ != 0);
      check("frame_cnt", frame_cnt, exp_frames);
      check("err_cnt", err_cnt, exp_errs);
      if (occ == 0) begin
        check("empty_head", {out_data, out_f, out_g, out_kind, out_err}, '0);
      end else begin
        exp_head = exp_q[0];
        check("head_data", out_data, exp_head.data);
        check("head_f", out_f, exp_head.f);
        check("head_g", out_g, exp_head.g);
        check("head_kind", out_kind, exp_head.kind);
        check("head_err", out_err, exp_head.err);
        if (out_ready) void'(exp_q.pop_front());
      end
      if (in_valid && occ < DEPTH) begin
        nxt = model(in_frame, in_mode);
        exp_q.push_back(nxt);
        if (exp_frames < CNT_MAX) exp_frames++;
        if (nxt.err && exp_errs < CNT_MAX) exp_errs++;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    drive(1'b1, 1'b0, 2'b00, '0, 1'b0);
    @(negedge clk);
    step();
    step();

    // Idle after reset
    drive(1'b0, 1'b0, 2'b00, '0, 1'b1);
    step();
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, '0);

    // DUP, clean
    drive(1'b0, 1'b1, 2'b11, {2'b00, H_A, H_A}, 1'b1);
    step();
    drive(1'b0, 1'b0, 2'b00, '0, 1'b1);
    check("dup_valid", out_valid, 1'b1);
    check("dup_kind", out_kind, 2'd2);
    check("dup_data", out_data, 128'h0000000000000000fedcba9876543210);
    check("dup_err", out_err, 1'b0);
    check("dup_cnt", frame_cnt, 4'd1);
    step();

    // FULL
    drive(1'b0, 1'b1, 2'b01, {2'b10, 128'h0123456789abcdeffedcba9876543210}, 1'b1);
    step();
    drive(1'b0, 1'b0, 2'b00, '0, 1'b1);
    check("full_f", out_f, 1'b1);
    check("full_g", out_g, 1'b0);
    check("full_data", out_data, 128'h0123456789abcdeffedcba9876543210);
    check("full_kind", out_kind, 2'd1);
    check("full_err", out_err, 1'b0);
    step();

    // DUP with mismatched halves
    drive(1'b0, 1'b1, 2'b11, {2'b00, H_B, H_A}, 1'b1);
    step();
    drive(1'b0, 1'b0, 2'b00, '0, 1'b1);
    check("dup_bad_err", out_err, 1'b1);
    check("dup_bad_errcnt", err_cnt, 4'd1);
    step();

    // DUP with equal halves but frame[128] set
    drive(1'b0, 1'b1, 2'b11, {2'b01, H_A, H_A}, 1'b1);
    step();
    drive(1'b0, 1'b0, 2'b00, '0, 1'b1);
    check("dup_g_errcnt", err_cnt, 4'd2);
    step();

    // NULL tags: clean zero frame and a corrupted one
    drive(1'b0, 1'b1, 2'b10, '0, 1'b1);
    step();
    drive(1'b0, 1'b1, 2'b00, 130'h1, 1'b1);
    step();
    drive(1'b0, 1'b0, 2'b00, '0, 1'b1);
    check("null_err", out_err, 1'b1);
    step();

    // Backpressure: three frames against a two-entry FIFO
    drive(1'b0, 1'b1, 2'b01, 130'hA, 1'b0);
    step();
    drive(1'b0, 1'b1, 2'b01, 130'hB, 1'b0);
    step();
    drive(1'b0, 1'b1, 2'b01, 130'hC, 1'b0);
    check("bp_full_ready", in_ready, 1'b0);
    step();
    step();
    drive(1'b0, 1'b1, 2'b01, 130'hC, 1'b1);
    step();  // pops A; still full at the edge, C not taken
    step();  // pops B and accepts C together
    check("bp_occ1_valid", out_valid, 1'b1);
    check("bp_occ1_ready", in_ready, 1'b1);
    check("bp_head_c", out_data, 128'hC);
    drive(1'b0, 1'b0, 2'b00, '0, 1'b1);
    step();
    step();

    // Reset mid-burst with a frame presented
    drive(1'b0, 1'b1, 2'b01, 130'h11, 1'b0);
    step();
    drive(1'b0, 1'b1, 2'b01, 130'h22, 1'b0);
    step();
    drive(1'b1, 1'b1, 2'b01, 130'h33, 1'b0);
    step();
    drive(1'b0, 1'b0, 2'b00, '0, 1'b1);
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_frames", frame_cnt, 4'd0);
    check("mid_rst_errs", err_cnt, 4'd0);
    check("mid_rst_data", out_data, '0);
    step();

    // Saturation: 20 clean then 20 errored accepts
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b1, 2'b01, 130'(i + 1), 1'b1);
      step();
    end
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b1, 2'b00, 130'(i + 1), 1'b1);
      step();
    end
    drive(1'b0, 1'b0, 2'b00, '0, 1'b1);
    step();
    step();
    check("sat_frames", frame_cnt, 4'd15);
    check("sat_errs", err_cnt, 4'd15);
    check("sat_drained", out_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
